// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide step sequencer:
// state encoding, AD function codes, ADB / AR / MQ select codes.
package md_pkg;

  // Sequencer states. DIV_CHK is only reachable when the divide overflow
  // pre-check is built in.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_STEP = 3'd1,
    DIV_STEP = 3'd2,
    DIV_FIX  = 3'd3,
    DONE     = 3'd4,
    DIV_CHK  = 3'd5
  } md_state_e;

  // AD function codes (octal, as written in the microcode listings)
  localparam logic [6:0] AD_A   = 7'o37;
  localparam logic [6:0] AD_APB = 7'o06;
  localparam logic [6:0] AD_AMB = 7'o51;

  // ADA select: AR onto the A side
  localparam logic [3:0] ADA_AR = 4'd0;

  // ADB select codes
  localparam logic [2:0] ADB_FM    = 3'd0;
  localparam logic [2:0] ADB_BR_X2 = 3'd1;
  localparam logic [2:0] ADB_BR    = 3'd2;
  localparam logic [2:0] ADB_AR_X4 = 3'd3;

  // MQ shifter controls
  localparam logic [1:0] USR_LOAD = 2'd0;
  localparam logic [1:0] USR_SHL  = 2'd1;
  localparam logic [1:0] USR_SHR  = 2'd2;
  localparam logic [1:0] USR_HOLD = 2'd3;

  // MQM mux: ADX bits into MQ
  localparam logic [1:0] MQM_ADX = 2'd0;

  // AR / ARX half select codes
  localparam logic [2:0] AR_SEL_HOLD    = 3'd0;
  localparam logic [2:0] AR_SEL_AD      = 3'd2;
  localparam logic [2:0] AR_SEL_AD_X2   = 3'd5;
  localparam logic [2:0] AR_SEL_AD_DIV4 = 3'd7;

endpackage

// File: rtl/md_booth_dec.sv
// Radix-4 Booth recoder: {MQ[34], MQ[35], previous MQ[34]} -> AD function
// and ADB select. Purely combinational.
module md_booth_dec
  import md_pkg::*;
(
  input  logic [2:0] triple,
  output logic [6:0] cram_ad,
  output logic [2:0] cram_adb
);

  // Recode the bit triple into add/subtract of BR or 2*BR
  always_comb begin
    cram_ad  = AD_A;
    cram_adb = ADB_BR;
    case (triple)
      3'b000, 3'b111: begin cram_ad = AD_A;   cram_adb = ADB_BR;    end
      3'b001, 3'b010: begin cram_ad = AD_APB; cram_adb = ADB_BR;    end
      3'b011:         begin cram_ad = AD_APB; cram_adb = ADB_BR_X2; end
      3'b100:         begin cram_ad = AD_AMB; cram_adb = ADB_BR_X2; end
      3'b101, 3'b110: begin cram_ad = AD_AMB; cram_adb = ADB_BR;    end
      default:        begin cram_ad = AD_A;   cram_adb = ADB_BR;    end
    endcase
  end

endmodule

// File: rtl/md_step_seq.sv
// EBOX multiply/divide step sequencer. Drives the AD/ADA/ADB, AR/ARX and
// MQ/MQM controls each step and consumes MQ low bits, AD sign and AD carry.
// Radix-4 Booth multiply (2 bits/step), non-restoring divide (1 bit/step).
// Optional build macro MD_DIV_OVF_CHECK_EN adds a one-cycle divide overflow
// pre-check (DIV_CHK); without it div_ovf is tied low.
module md_step_seq
  import md_pkg::*;
#(
  parameter int STEP_W    = 6,
  parameter int MUL_STEPS = 18,
  parameter int DIV_STEPS = 36
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              op_div,
  input  logic              abort,
  input  logic [0:1]        mq_low,     // MQ[34:35], MQ[34] at index 0
  input  logic              ad_sign,
  input  logic              ad_cry0,
  output logic [6:0]        cram_ad,
  output logic [3:0]        cram_ada,
  output logic [2:0]        cram_adb,
  output logic [2:0]        arl_sel,
  output logic [2:0]        arr_sel,
  output logic              ar_load,
  output logic [2:0]        arxl_sel,
  output logic [2:0]        arxr_sel,
  output logic              arx_load,
  output logic [1:0]        mq_sel,
  output logic [1:0]        mqm_sel,
  output logic              mqm_en,
  output logic              busy,
  output logic              done,
  output logic              div_ovf,
  output logic [STEP_W-1:0] step_count
);

  md_state_e          state_reg, state_next;
  logic [STEP_W-1:0]  step_count_reg;
  logic               booth_prev_reg;
  logic               q_prev_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               last_step;
  logic               start_ok;
  logic [6:0]         booth_ad;
  logic [2:0]         booth_adb;

  assign last_step = (step_count_reg <= STEP_W'(1));
  assign start_ok  = start && !abort;

  md_booth_dec u_booth (
    .triple   ({mq_low[0], mq_low[1], booth_prev_reg}),
    .cram_ad  (booth_ad),
    .cram_adb (booth_adb)
  );

  // Next-state and per-step data path controls; hold values by default
  always_comb begin
    state_next = state_reg;
    cram_ad    = AD_A;
    cram_ada   = ADA_AR;
    cram_adb   = ADB_BR;
    arl_sel    = AR_SEL_HOLD;
    arr_sel    = AR_SEL_HOLD;
    ar_load    = 1'b0;
    arxl_sel   = AR_SEL_HOLD;
    arxr_sel   = AR_SEL_HOLD;
    arx_load   = 1'b0;
    mq_sel     = USR_HOLD;
    mqm_sel    = MQM_ADX;
    mqm_en     = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start_ok) begin
          if (op_div) begin
`ifdef MD_DIV_OVF_CHECK_EN
            state_next = DIV_CHK;
`else
            state_next = DIV_STEP;
`endif
          end else begin
            state_next = MUL_STEP;
          end
        end
      end

      MUL_STEP: begin
        // AD>>2 into AR, low ADX bits shift into the top of MQ
        cram_ad  = booth_ad;
        cram_adb = booth_adb;
        arl_sel  = AR_SEL_AD_DIV4;
        arr_sel  = AR_SEL_AD_DIV4;
        ar_load  = 1'b1;
        mq_sel   = USR_LOAD;
        mqm_sel  = MQM_ADX;
        mqm_en   = 1'b1;
        if (last_step) state_next = DONE;
      end

      DIV_STEP: begin
        // Subtract while the partial remainder is non-negative, else add back
        cram_ad  = q_prev_reg ? AD_AMB : AD_APB;
        cram_adb = ADB_BR;
        arl_sel  = AR_SEL_AD_X2;
        arr_sel  = AR_SEL_AD_X2;
        ar_load  = 1'b1;
        mq_sel   = USR_SHL;
        if (last_step) state_next = ad_sign ? DIV_FIX : DONE;
      end

      DIV_FIX: begin
        // Final remainder was negative: add the divisor back once
        cram_ad  = AD_APB;
        cram_adb = ADB_BR;
        arl_sel  = AR_SEL_AD;
        arr_sel  = AR_SEL_AD;
        ar_load  = 1'b1;
        state_next = DONE;
      end

`ifdef MD_DIV_OVF_CHECK_EN
      DIV_CHK: begin
        // Trial subtract of the divisor from the high dividend, nothing loaded
        cram_ad  = AD_AMB;
        cram_adb = ADB_BR;
        state_next = ad_cry0 ? DONE : DIV_STEP;
      end
`endif

      DONE: state_next = IDLE;

      default: state_next = IDLE;
    endcase

    // Abort cancels any operation and also beats a simultaneous start
    if (abort) state_next = IDLE;
  end

  // State, step counter and recode/quotient history registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      step_count_reg <= '0;
      booth_prev_reg <= 1'b0;
      q_prev_reg     <= 1'b0;
      busy_reg       <= 1'b0;
      done_reg       <= 1'b0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != IDLE);
      done_reg  <= (state_next == DONE);
      case (state_reg)
        IDLE: begin
          if (start_ok) begin
            step_count_reg <= op_div ? STEP_W'(DIV_STEPS) : STEP_W'(MUL_STEPS);
            booth_prev_reg <= 1'b0;
            q_prev_reg     <= 1'b1;
          end
        end
        MUL_STEP: begin
          booth_prev_reg <= mq_low[0];
          if (step_count_reg != '0) step_count_reg <= step_count_reg - STEP_W'(1);
        end
        DIV_STEP: begin
          q_prev_reg <= ~ad_sign;
          if (step_count_reg != '0) step_count_reg <= step_count_reg - STEP_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef MD_DIV_OVF_CHECK_EN
  logic div_ovf_reg;

  // Overflow flag: cleared by an accepted start, set by a failed pre-check
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_ovf_reg <= 1'b0;
    end else if (state_reg == IDLE && start_ok) begin
      div_ovf_reg <= 1'b0;
    end else if (state_reg == DIV_CHK && ad_cry0 && !abort) begin
      div_ovf_reg <= 1'b1;
    end
  end

  assign div_ovf = div_ovf_reg;
`else
  logic unused_cry0;
  assign unused_cry0 = ad_cry0;
  assign div_ovf     = 1'b0;
`endif

  assign busy       = busy_reg;
  assign done       = done_reg;
  assign step_count = step_count_reg;

endmodule

// File: doc/md_step_seq.md
Name: md_step_seq

Overview:
- Multiply/divide step sequencer for the EBOX data path.
- Sits directly upstream of the AR/ARX/MQ/AD data path. Each step cycle it drives the AD function, the ADA/ADB selects, the AR/ARX load selects and the MQ/MQM selects.
- Consumes the data path's feedback: the MQ low bits, the AD sign and the AD carry-out.
- Implements radix-4 Booth multiply (2 bits per step) and non-restoring divide (1 bit per step).

Parameters:
- STEP_W, 6, width of the step counter.
- MUL_STEPS, 18, Booth steps for a 36-bit multiplier.
- DIV_STEPS, 36, quotient bits per divide.

Ports:
- clk  in  1  EBOX clock; all state changes on rising edge.
- reset_n  in  1  synchronous active-low reset.
- start  in  1  begin operation; sampled only in IDLE.
- op_div  in  1  0 = multiply, 1 = divide; sampled with start.
- abort  in  1  synchronous cancel.
- mq_low  in  2  EDP_MQ[34:35].
- ad_sign  in  1  EDP_AD[0].
- ad_cry0  in  1  AD carry-out of bit 0 (ADcarry[-2]).
- cram_ad  out  7  AD function code, octal.
- cram_ada  out  4  ADA enable/select.
- cram_adb  out  3  ADB select: 0 = FM, 1 = BR*2, 2 = BR, 3 = AR*4.
- arl_sel, arr_sel  out  3 each  AR half selects.
- ar_load  out  1  load all of AR.
- arxl_sel, arxr_sel  out  3 each  ARX half selects.
- arx_load  out  1  load ARX.
- mq_sel, mqm_sel  out  2 each  MQ shifter / MQM mux controls.
- mqm_en  out  1  MQM enable.
- busy  out  1  operation in progress.
- done  out  1  one-cycle completion pulse.
- div_ovf  out  1  divide overflow flag, sticky until next start.
- step_count  out  STEP_W  remaining steps.

Behaviour:
- States: IDLE, MUL_STEP, DIV_STEP, DIV_FIX, DONE (plus DIV_CHK under the optional feature).
- Reset values: state IDLE; busy, done, div_ovf, booth_prev, q_prev = 0; step_count = 0.
- Control outputs are combinational from state, registers and feedback.
- In IDLE, DONE and reset, all controls take hold values:
  - ar_load = arx_load = 0, mq_sel = 3 (HOLD), mqm_en = 0.
  - cram_ad = 7'o37 (A), cram_ada = 0, cram_adb = 2.
- IDLE + start:
  - Next cycle enters MUL_STEP (op_div = 0) or DIV_STEP (op_div = 1).
  - Loads step_count with MUL_STEPS or DIV_STEPS.
  - Clears booth_prev and div_ovf; sets q_prev = 1.
  - busy = 1 from that cycle until DONE exits.
- MUL_STEP: Booth recode of {mq_low[0], mq_low[1], booth_prev}.
  - 000/111: AD = A (37).
  - 001/010: AD = A+B (06), adb = 2.
  - 011: AD = A+B, adb = 1.
  - 100: AD = A-B (51), adb = 1.
  - 101/110: AD = A-B, adb = 2.
  - All cases: arl_sel = arr_sel = 7 (AD>>2 into AR); ar_load = 1; mq_sel = 0, mqm_sel = 0, mqm_en = 1 (MQ <- {ADX[34:35], MQ[0:33]}).
  - Register update: booth_prev <= mq_low[0].
- DIV_STEP:
  - AD = A-B if q_prev else A+B; adb = 2.
  - arl_sel = arr_sel = 5 (AD<<1); ar_load = 1; mq_sel = 1 (shift left, ADcarry in).
  - Register update: q_prev <= ~ad_sign.
- Step counting: step_count decrements each step. The step performed with step_count = 1 is the last:
  - Multiply then goes to DONE.
  - Divide goes to DIV_FIX if ~ad_sign == 0 (remainder negative), else to DONE.
- DIV_FIX: AD = A+B, adb = 2, arl_sel = arr_sel = 2, ar_load = 1, MQ held; then DONE.
- DONE: done = 1 for exactly one cycle, busy = 0 next cycle, return to IDLE.
- Boundary conditions:
  - start while busy: ignored.
  - start and abort together in IDLE: abort wins, stay IDLE.
  - abort in any busy state: next cycle IDLE, busy = 0, no done, div_ovf retained.
  - reset_n low mid-operation: IDLE on that edge; controls hold from the next cycle.
  - step_count never wraps; it is only decremented while nonzero.

Optional Feature:
- Macro: MD_DIV_OVF_CHECK_EN.
- Defined:
  - Divide start enters DIV_CHK for one cycle: AD = A-B, adb = 2, no loads.
  - If ad_cry0 = 1 (|high dividend| >= divisor): div_ovf <= 1, go to DONE without steps, AR/ARX/MQ untouched.
  - Otherwise enter DIV_STEP.
- Undefined: no DIV_CHK; div_ovf is tied 0.

Decomposition:
- Shared package md_pkg holds:
  - state enum;
  - AD function codes (AD_A = 7'o37, AD_APB = 7'o06, AD_AMB = 7'o51);
  - ADB select codes;
  - USR_LOAD/SHL/SHR/HOLD;
  - ARL/ARR select codes.
- One sub-module, md_booth_dec: combinational 3-bit Booth recode to {cram_ad, cram_adb}.

Test Plan:
- Reset held 2 cycles mid-MUL_STEP (step_count = 9) → state IDLE, busy = 0, ar_load = 0, mq_sel = 3, step_count = 0.
- start, op_div = 0, mq_low stream 2'b01 every step → 18 MUL_STEP cycles:
  - first step: cram_ad = 06, adb = 2;
  - subsequent steps: booth_prev = 0 → adb = 2, AD = 06;
  - done pulses at cycle 20 after start.
- Booth recode sweep: force each of 8 {mq_low, booth_prev} combos → cram_ad/adb match the MUL_STEP table exactly.
- Divide with ad_sign = 1 on the final step → DIV_FIX asserted one cycle with cram_ad = 06, ar_load = 1, then done.
- abort at step 5 of divide → next cycle IDLE, busy = 0, done never asserts; a later start restarts with step_count = 36.
- MD_DIV_OVF_CHECK_EN defined, ad_cry0 = 1 in DIV_CHK → div_ovf = 1, done on cycle 3, ar_load never asserted.
